// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
//   state_t          - fetch FSM states
//   NOP_INSTR        - instruction presented while nothing is held (addi x0,x0,0)
//   RESET_PC_DEFAULT - default PC loaded on reset
package fetch_pkg;

    typedef enum logic [1:0] {FETCH, WAIT, VALID, HALT} state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory request/response bus
//   imem_req    - one-cycle fetch request (master -> slave)
//   imem_addr   - fetch address (master -> slave)
//   imem_rvalid - response valid (slave -> master)
//   imem_rdata  - response data (slave -> master)
interface instr_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);

endinterface

// File: rtl/instr_fetch_pc_next.sv
// pc_next: combinational next-PC selection, shared with future jump support
//   PC         - current program counter
//   ImmExt     - sign-extended branch offset
//   PCSrc      - select PC + ImmExt instead of PC + 4
//   PCPlus4    - PC + 4 (modulo 2^32)
//   target     - selected next PC
//   misaligned - target is not word aligned
module pc_next (
    input  logic [31:0] PC,
    input  logic [31:0] ImmExt,
    input  logic        PCSrc,
    output logic [31:0] PCPlus4,
    output logic [31:0] target,
    output logic        misaligned
);

    assign PCPlus4    = PC + 32'd4;
    assign target     = PCSrc ? PC + ImmExt : PCPlus4;
    assign misaligned = |target[1:0];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and one-at-a-time instruction fetch from variable-latency memory
//   clk, reset  - clock and synchronous active-high reset
//   PCSrc       - branch taken, used only on a retire cycle
//   ImmExt      - branch offset, used only on a retire cycle
//   Advance     - downstream retires the held instruction
//   imem        - instruction memory bus (master side)
//   Instr       - held instruction, NOP_INSTR when none is held
//   InstrValid  - Instr is valid for decode
//   PC          - address of the current or pending instruction
//   PCPlus4     - PC + 4, combinational
//   Fault       - sticky misaligned-target fault
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 PCSrc,
    input  logic [31:0]          ImmExt,
    input  logic                 Advance,
    instr_fetch_if.master        imem,
    output logic [31:0]          Instr,
    output logic                 InstrValid,
    output logic [31:0]          PC,
    output logic [31:0]          PCPlus4,
    output logic                 Fault
);

    state_t      state;
    logic [31:0] target;
    logic        misaligned;

    pc_next u_pc_next (
        .PC         (PC),
        .ImmExt     (ImmExt),
        .PCSrc      (PCSrc),
        .PCPlus4    (PCPlus4),
        .target     (target),
        .misaligned (misaligned)
    );

    // Request is a pure decode of state; gating with reset keeps the bus quiet
    // in the cycle reset is first asserted, before the state register clears.
    assign imem.imem_req  = (state == FETCH) && !reset;
    assign imem.imem_addr = PC;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            PC         <= RESET_PC;
            Instr      <= NOP_INSTR;
            InstrValid <= 1'b0;
            Fault      <= 1'b0;
        end else begin
            case (state)
                FETCH: state <= WAIT;
                WAIT: if (imem.imem_rvalid) begin
                    Instr      <= imem.imem_rdata;
                    InstrValid <= 1'b1;
                    state      <= VALID;
                end
                VALID: if (Advance) begin
                    // PC takes the faulting target too, so it is visible for debug.
                    PC         <= target;
                    Instr      <= NOP_INSTR;
                    InstrValid <= 1'b0;
                    Fault      <= misaligned;
                    state      <= misaligned ? HALT : FETCH;
                end
                HALT: state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

endmodule
